// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU operation sequencer: opcodes, widths, FSM states.
package alu_pkg;

   localparam int OPND_W = 4;
   localparam int RES_W  = 8;

   localparam logic [2:0] OP_RIPPLE = 3'b000;
   localparam logic [2:0] OP_PLUS   = 3'b001;
   localparam logic [2:0] OP_ORXOR  = 3'b011;
   localparam logic [2:0] OP_ANY    = 3'b100;
   localparam logic [2:0] OP_ALL    = 3'b101;
   localparam logic [2:0] OP_CONCAT = 3'b110;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SETTLE  = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_RESP    = 2'd3
   } seq_state_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Command and response handshakes between the key/switch front end and the sequencer.
interface alu_op_sequencer_if;
   import alu_pkg::*;

   logic              cmd_valid;
   logic              cmd_ready;
   logic [2:0]        cmd_op;
   logic [OPND_W-1:0] cmd_a;
   logic [OPND_W-1:0] cmd_b;
   logic              cmd_use_acc;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [RES_W-1:0]  rsp_data;

   modport master (
      output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data
   );

endinterface

// File: rtl/alu_op_sequencer_ref_model.sv
// Combinational reference of the expected ALU result, used by the optional self-check.
module alu_ref_model
   import alu_pkg::*;
(
   input  logic [OPND_W-1:0] a,
   input  logic [OPND_W-1:0] b,
   input  logic [2:0]        key,
   output logic [RES_W-1:0]  result
);

   logic [OPND_W:0] sum_s;

   // Expected result per opcode; undefined opcodes read as zero.
   always_comb begin
      sum_s  = {1'b0, a} + {1'b0, b};
      result = {RES_W{1'b0}};
      case (key)
         OP_RIPPLE, OP_PLUS: result = {3'b000, sum_s};
         OP_ORXOR:           result = {a | b, a ^ b};
         OP_ANY:             result = {7'b0000000, |{a, b}};
         OP_ALL:             result = {7'b0000000, &{a, b}};
         OP_CONCAT:          result = {a, b};
         default:            result = {RES_W{1'b0}};
      endcase
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequencer driving the combinational ALU: accept, settle, capture, respond.
// Optional ALU_SELFCHECK_EN adds a sticky mismatch flag against alu_ref_model.
module alu_op_sequencer
   import alu_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1,
   parameter int CNT_W         = 8
)
(
   input  logic               clk,
   input  logic               resetn,
   alu_op_sequencer_if.slave  bus,
   output logic [OPND_W-1:0]  alu_a,
   output logic [OPND_W-1:0]  alu_b,
   output logic [2:0]         alu_key,
   input  logic [RES_W-1:0]   alu_out,
   output logic [RES_W-1:0]   acc,
   output logic [CNT_W-1:0]   op_count
`ifdef ALU_SELFCHECK_EN
   ,
   output logic               mismatch
`endif
);

   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

   seq_state_t state_r;
   logic [3:0] settle_cnt_r;

   // Main FSM; every handshake and ALU-facing output is a register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_r       <= ST_IDLE;
         settle_cnt_r  <= 4'd0;
         alu_a         <= {OPND_W{1'b0}};
         alu_b         <= {OPND_W{1'b0}};
         alu_key       <= 3'b000;
         acc           <= {RES_W{1'b0}};
         op_count      <= {CNT_W{1'b0}};
         bus.cmd_ready <= 1'b1;
         bus.rsp_valid <= 1'b0;
         bus.rsp_data  <= {RES_W{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (bus.cmd_valid) begin
                  alu_a         <= bus.cmd_a;
                  alu_key       <= bus.cmd_op;
                  // acc is sampled here, so a chained op sees the value just captured
                  alu_b         <= bus.cmd_use_acc ? acc[OPND_W-1:0] : bus.cmd_b;
                  settle_cnt_r  <= SETTLE_LOAD;
                  bus.cmd_ready <= 1'b0;
                  state_r       <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (settle_cnt_r == 4'd0) begin
                  state_r <= ST_CAPTURE;
               end else begin
                  settle_cnt_r <= settle_cnt_r - 4'd1;
               end
            end
            ST_CAPTURE: begin
               bus.rsp_data  <= alu_out;
               acc           <= alu_out;
               bus.rsp_valid <= 1'b1;
               state_r       <= ST_RESP;
            end
            ST_RESP: begin
               if (bus.rsp_ready) begin
                  op_count      <= op_count + CNT_W'(1);
                  bus.rsp_valid <= 1'b0;
                  bus.cmd_ready <= 1'b1;
                  state_r       <= ST_IDLE;
               end
            end
            default: begin
               bus.rsp_valid <= 1'b0;
               bus.cmd_ready <= 1'b1;
               state_r       <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef ALU_SELFCHECK_EN
   logic [RES_W-1:0] ref_result_s;

   alu_ref_model u_ref_model (
      .a      (alu_a),
      .b      (alu_b),
      .key    (alu_key),
      .result (ref_result_s)
   );

   // Sticky flag: any capture that disagrees with the reference latches it until reset.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         mismatch <= 1'b0;
      end else if ((state_r == ST_CAPTURE) && (alu_out != ref_result_s)) begin
         mismatch <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench: one sequencer with SETTLE_CYCLES=1 and one with 4, each fed by a behavioural ALU.
module tb_alu_op_sequencer;

   logic       clk = 1'b0;
   logic       resetn1 = 1'b0;
   logic       resetn4 = 1'b0;
   logic       fault = 1'b0;
   logic [3:0] a1, b1, a4, b4;
   logic [2:0] key1, key4;
   logic [7:0] out1, out4, acc1, acc4, cnt1, cnt4;
   int         total_cnt = 0;
   int         pass_cnt  = 0;
   int         fail_cnt  = 0;
   int         ops_done  = 0;
   int         lat;
   logic [7:0] held;
`ifdef ALU_SELFCHECK_EN
   logic       mm1, mm4;
`endif

   alu_op_sequencer_if bus1 ();
   alu_op_sequencer_if bus4 ();

   always #5 clk = ~clk;

   function automatic logic [7:0] model_alu(input logic [2:0] k, input logic [3:0] a, input logic [3:0] b);
      logic [4:0] s;
      s = {1'b0, a} + {1'b0, b};
      case (k)
         3'b000, 3'b001: model_alu = {3'b000, s};
         3'b011:         model_alu = {a | b, a ^ b};
         3'b100:         model_alu = {7'b0000000, |{a, b}};
         3'b101:         model_alu = {7'b0000000, &{a, b}};
         3'b110:         model_alu = {a, b};
         default:        model_alu = 8'h00;
      endcase
   endfunction

   // DUT1's ALU can be made to force bit 0 high on the OR/XOR opcode.
   assign out1 = model_alu(key1, a1, b1) | ((fault && key1 == 3'b011) ? 8'h01 : 8'h00);
   assign out4 = model_alu(key4, a4, b4);

   alu_op_sequencer #(.SETTLE_CYCLES(1), .CNT_W(8)) u_dut1 (
      .clk      (clk),
      .resetn   (resetn1),
      .bus      (bus1.slave),
      .alu_a    (a1),
      .alu_b    (b1),
      .alu_key  (key1),
      .alu_out  (out1),
      .acc      (acc1),
      .op_count (cnt1)
`ifdef ALU_SELFCHECK_EN
      ,
      .mismatch (mm1)
`endif
   );

   alu_op_sequencer #(.SETTLE_CYCLES(4), .CNT_W(8)) u_dut4 (
      .clk      (clk),
      .resetn   (resetn4),
      .bus      (bus4.slave),
      .alu_a    (a4),
      .alu_b    (b4),
      .alu_key  (key4),
      .alu_out  (out4),
      .acc      (acc4),
      .op_count (cnt4)
`ifdef ALU_SELFCHECK_EN
      ,
      .mismatch (mm4)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) begin
         pass_cnt++;
      end else begin
         fail_cnt++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present one command to DUT1 for a single accepting edge, then count cycles to rsp_valid.
   task automatic issue1(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, input logic ua);
      bus1.cmd_op = op; bus1.cmd_a = a; bus1.cmd_b = b; bus1.cmd_use_acc = ua;
      bus1.cmd_valid = 1'b1;
      tick();
      bus1.cmd_valid = 1'b0;
      lat = 1;
      while (!bus1.rsp_valid && lat < 40) begin
         tick();
         lat++;
      end
   endtask

   // With rsp_ready high, one edge completes the response.
   task automatic finish1();
      tick();
      ops_done++;
      check("op_count", {24'h0, cnt1}, ops_done % 256);
      check("cmd_ready_back", {31'h0, bus1.cmd_ready}, 32'd1);
   endtask

   initial begin
      bus1.cmd_valid = 1'b0; bus1.cmd_op = 3'b000; bus1.cmd_a = 4'h0; bus1.cmd_b = 4'h0;
      bus1.cmd_use_acc = 1'b0; bus1.rsp_ready = 1'b1;
      bus4.cmd_valid = 1'b0; bus4.cmd_op = 3'b000; bus4.cmd_a = 4'h0; bus4.cmd_b = 4'h0;
      bus4.cmd_use_acc = 1'b0; bus4.rsp_ready = 1'b1;
      tick(); tick();
      check("rst_rsp_valid", {31'h0, bus1.rsp_valid}, 32'd0);
      check("rst_acc", {24'h0, acc1}, 32'h0);
      check("rst_op_count", {24'h0, cnt1}, 32'h0);
      resetn1 = 1'b1;
      resetn4 = 1'b1;
      tick();
      check("rst_cmd_ready", {31'h0, bus1.cmd_ready}, 32'd1);

      // Reset during SETTLE on the 4-cycle instance
      bus4.cmd_op = 3'b110; bus4.cmd_a = 4'h3; bus4.cmd_b = 4'h5; bus4.cmd_valid = 1'b1;
      tick();
      bus4.cmd_valid = 1'b0;
      check("s4_accepted", {31'h0, bus4.cmd_ready}, 32'd0);
      check("s4_alu_a", {28'h0, a4}, 32'h3);
      tick();
      resetn4 = 1'b0;
      #1;
      check("midrst_alu_a", {28'h0, a4}, 32'h0);
      check("midrst_alu_b", {28'h0, b4}, 32'h0);
      check("midrst_alu_key", {29'h0, key4}, 32'h0);
      check("midrst_rsp_data", {24'h0, bus4.rsp_data}, 32'h0);
      check("midrst_rsp_valid", {31'h0, bus4.rsp_valid}, 32'd0);
      tick();
      resetn4 = 1'b1;
      tick();
      check("midrst_cmd_ready", {31'h0, bus4.cmd_ready}, 32'd1);
      for (int i = 0; i < 8; i++) tick();
      check("midrst_lost_rsp", {31'h0, bus4.rsp_valid}, 32'd0);
      check("midrst_op_count", {24'h0, cnt4}, 32'h0);
      check("midrst_acc", {24'h0, acc4}, 32'h0);

      // Latency SETTLE_CYCLES+2 = 6 on the 4-cycle instance
      bus4.cmd_op = 3'b011; bus4.cmd_a = 4'hC; bus4.cmd_b = 4'hA; bus4.cmd_valid = 1'b1;
      tick();
      bus4.cmd_valid = 1'b0;
      lat = 1;
      while (!bus4.rsp_valid && lat < 40) begin
         tick();
         lat++;
      end
      check("s4_latency", lat, 32'd6);
      check("s4_rsp_data", {24'h0, bus4.rsp_data}, 32'hE6);
      tick();
      check("s4_op_count", {24'h0, cnt4}, 32'h1);

      // Ripple add with carry out
      issue1(3'b000, 4'hF, 4'h1, 1'b0);
      check("add_latency", lat, 32'd3);
      check("add_rsp_data", {24'h0, bus1.rsp_data}, 32'h10);
      check("add_acc", {24'h0, acc1}, 32'h10);
      finish1();

      // Chain: concat result feeds operand B of the next op
      issue1(3'b110, 4'h3, 4'h5, 1'b0);
      check("concat_rsp_data", {24'h0, bus1.rsp_data}, 32'h35);
      finish1();
      issue1(3'b001, 4'h2, 4'hE, 1'b1);
      check("chain_alu_b", {28'h0, b1}, 32'h5);
      check("chain_rsp_data", {24'h0, bus1.rsp_data}, 32'h07);
      check("chain_acc", {24'h0, acc1}, 32'h07);
      finish1();

      issue1(3'b111, 4'hF, 4'hF, 1'b0);
      check("undef_rsp_data", {24'h0, bus1.rsp_data}, 32'h00);
      finish1();
      issue1(3'b011, 4'hC, 4'hA, 1'b0);
      check("orxor_rsp_data", {24'h0, bus1.rsp_data}, 32'hE6);
      finish1();
      issue1(3'b100, 4'h0, 4'h0, 1'b0);
      check("any_rsp_data", {24'h0, bus1.rsp_data}, 32'h00);
      finish1();
      issue1(3'b101, 4'hF, 4'hF, 1'b0);
      check("all_rsp_data", {24'h0, bus1.rsp_data}, 32'h01);
      finish1();

      // Back-pressure with a competing command held valid
      bus1.rsp_ready = 1'b0;
      issue1(3'b100, 4'h1, 4'h0, 1'b0);
      held = bus1.rsp_data;
      check("bp_rsp_data", {24'h0, held}, 32'h01);
      bus1.cmd_op = 3'b110; bus1.cmd_a = 4'h9; bus1.cmd_b = 4'h9; bus1.cmd_valid = 1'b1;
      for (int i = 0; i < 10; i++) tick();
      check("bp_cmd_ready", {31'h0, bus1.cmd_ready}, 32'd0);
      check("bp_rsp_valid", {31'h0, bus1.rsp_valid}, 32'd1);
      check("bp_rsp_stable", {24'h0, bus1.rsp_data}, 32'h01);
      check("bp_alu_a", {28'h0, a1}, 32'h1);
      check("bp_alu_key", {29'h0, key1}, 32'h4);
      check("bp_op_count", {24'h0, cnt1}, ops_done);
      bus1.cmd_valid = 1'b0;
      bus1.rsp_ready = 1'b1;
      finish1();
      tick(); tick();
      check("bp_single_incr", {24'h0, cnt1}, ops_done);

      // Run up to 256 completed ops: op_count wraps to zero
      while (ops_done < 256) begin
         issue1(3'b001, 4'(ops_done), 4'(ops_done >> 4), 1'b0);
         check("wrap_sum", {24'h0, bus1.rsp_data}, (ops_done % 16) + ((ops_done >> 4) % 16));
         if (ops_done == 255) begin
            check("wrap_pre_ff", {24'h0, cnt1}, 32'hFF);
         end
         finish1();
      end
      check("wrap_zero", {24'h0, cnt1}, 32'h0);

`ifdef ALU_SELFCHECK_EN
      check("mm_clean", {31'h0, mm1}, 32'd0);
      check("mm4_clean", {31'h0, mm4}, 32'd0);
      fault = 1'b1;
      issue1(3'b011, 4'hC, 4'hA, 1'b0);
      check("mm_set", {31'h0, mm1}, 32'd1);
      check("mm_fault_data", {24'h0, bus1.rsp_data}, 32'hE7);
      finish1();
      fault = 1'b0;
      issue1(3'b110, 4'h1, 4'h2, 1'b0);
      check("mm_sticky", {31'h0, mm1}, 32'd1);
      finish1();
      resetn1 = 1'b0;
      #1;
      check("mm_reset", {31'h0, mm1}, 32'd0);
      resetn1 = 1'b1;
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Sequential front end for the 4-bit/8-bit combinational ALU.
- Accepts operation commands over a valid/ready handshake and drives the ALU operand and opcode inputs.
- Waits a programmable settle time, captures the 8-bit result into an accumulator, and returns it over a valid/ready response handshake.
- Sits between the switch/key input logic and the ALU. Its accumulator feeds back as operand B, enabling chained operations.

Parameters:
- SETTLE_CYCLES, 1: cycles that ALU inputs are held stable before capture; legal range 1..15.
- CNT_W, 8: width of the completed-operation counter.

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  3  ALU opcode (same encoding as ALU key input)
- cmd_a  in  4  operand A
- cmd_b  in  4  operand B, used when cmd_use_acc=0
- cmd_use_acc  in  1  1: operand B = acc[3:0]
- alu_a  out  4  to ALU A
- alu_b  out  4  to ALU B
- alu_key  out  3  to ALU opcode
- alu_out  in  8  from ALU result (combinational)
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_data  out  8  captured result
- acc  out  8  accumulator (last captured result)
- op_count  out  CNT_W  completed responses, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, resetn=0) clears all state immediately:
  - State=IDLE; acc, rsp_data, alu_a, alu_b, alu_key, op_count all 0.
  - rsp_valid=0; cmd_ready=1 as soon as resetn is released.
- FSM states are IDLE, SETTLE, CAPTURE, RESP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready: register alu_a=cmd_a, alu_key=cmd_op, and alu_b = cmd_use_acc ? acc[3:0] : cmd_b.
  - Load settle counter with SETTLE_CYCLES-1, then go to SETTLE.
- SETTLE:
  - cmd_ready=0; ALU inputs held stable.
  - Counter decrements each cycle; at 0 go to CAPTURE.
  - Time in SETTLE is exactly SETTLE_CYCLES cycles.
- CAPTURE:
  - One cycle; rsp_data<=alu_out and acc<=alu_out.
  - Go to RESP; rsp_valid asserts next cycle.
- RESP:
  - rsp_valid=1; rsp_data is stable until the handshake completes.
  - On rsp_ready: op_count++ and go to IDLE (cmd_ready=1 the following cycle).
- Latency from command acceptance to rsp_valid is SETTLE_CYCLES+2 cycles. No pipelining: at most one operation in flight.
- Back-pressure: rsp_ready low holds RESP indefinitely; no new command is accepted, and alu_* stay unchanged.
- cmd_use_acc samples acc at the acceptance edge, so a command issued right after a response uses the just-captured value.
- op_count wraps from all-ones to 0 without any flag.
- alu_* outputs are registered and remain at their last value in IDLE.
- resetn asserted mid-operation aborts immediately. The pending response is lost and op_count is not incremented.

Optional Feature:
- Macro: ALU_SELFCHECK_EN.
- Defined:
  - Adds output `mismatch` (1 bit, reset 0), sticky until reset.
  - In CAPTURE, alu_out is compared to an internal reference model:
    - 000/001: {3'b0, A+B} (5-bit sum)
    - 011: {A|B, A^B}
    - 100: {7'b0, |{A,B}}
    - 101: {7'b0, &{A,B}}
    - 110: {A,B}
    - others: 0
  - mismatch is set the cycle after any difference.
- Undefined: no port and no model logic; behaviour is otherwise identical.

Decomposition:
- Shared package alu_pkg:
  - Opcode localparams OP_RIPPLE=3'b000, OP_PLUS=3'b001, OP_ORXOR=3'b011, OP_ANY=3'b100, OP_ALL=3'b101, OP_CONCAT=3'b110.
  - State encoding localparams; widths OPND_W=4, RES_W=8.
- One natural sub-module: alu_ref_model (combinational expected-result function), instantiated only under ALU_SELFCHECK_EN.

Test Plan:
- Reset mid-SETTLE (SETTLE_CYCLES=4, cmd issued, resetn low at cycle 2) -> all outputs 0, cmd_ready=1 after release, op_count=0.
- op=000, A=4'hF, B=4'h1, use_acc=0, rsp_ready=1 -> rsp_valid at acceptance+3 (SETTLE_CYCLES=1), rsp_data=8'h10, acc=8'h10, op_count=1.
- Chain: op=110, A=3, B=5 -> 8'h35. Then op=001, A=2, use_acc=1 -> alu_b=5, rsp_data=8'h07.
- Back-pressure: rsp_ready=0 for 10 cycles with cmd_valid held high -> cmd_ready=0, rsp_data stable at its value, alu_* unchanged. On release, exactly one op_count increment.
- op=111 (undefined), A=F, B=F -> rsp_data=8'h00. 256 back-to-back ops with CNT_W=8 -> op_count wraps to 0.
- With ALU_SELFCHECK_EN, a faulty ALU forcing bit0 on op=011, A=4'hC, B=4'hA -> mismatch=1 from the cycle after CAPTURE and held until reset. With a correct ALU, mismatch stays 0.
